// File: rtl/dmem_lsu.sv
// ---------------------------------------------------------------------------
// dmem_lsu
// Load/store unit between the CPU MEM stage and data_mem. Byte-addressed
// LB/LBU/LH/LHU/LW/SB/SH/SW requests become word accesses. data_mem has no
// byte enables, so sub-word stores use read-modify-write. The unit waits out
// the fixed read latency and returns a one-cycle cpu_done pulse together with
// the formatted load data.
//
// Parameters:
//   RD_LATENCY  cycles mem_rdMem is held before mem_rdData is valid (>=1)
//   MEM_AW      word-address bits forwarded on mem_addr
//
// Optional feature macro: LSU_STORE_FWD_EN
//   Adds a one-entry store buffer. Loads and sub-word stores that hit the
//   buffer take the buffered word and skip the memory read.
//
// Ports:
//   clk, reset (async, active-low)
//   cpu_req/cpu_we/cpu_size/cpu_signed/cpu_addr/cpu_wdata : request
//   cpu_ready/cpu_done/cpu_err/cpu_rdata                  : handshake/result
//   mem_addr/mem_wrData/mem_rdMem/mem_wrMem/mem_rdData    : data_mem port
// ---------------------------------------------------------------------------
module dmem_lsu #(
  parameter int RD_LATENCY = 2,
  parameter int MEM_AW     = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_signed,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wrData,
  output logic        mem_rdMem,
  output logic        mem_wrMem,
  input  logic [31:0] mem_rdData
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_DONE, S_ERR
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(RD_LATENCY - 1);

  state_t              state, state_n;
  logic [7:0]          cnt;
  logic [MEM_AW+1:0]   addr_q;
  logic [1:0]          size_q;
  logic                signed_q;
  logic                we_q;
  logic [15:0]         wdata_q;
  logic [31:0]         wr_word;
  logic                req_bad;
  logic                fwd_hit;
  logic [31:0]         cap_word;
  logic [31:0]         load_val;
  logic [31:0]         merged;
  logic [7:0]          lane_b;
  logic [15:0]         lane_h;
  logic [4:0]          sh_b;
  logic [4:0]          sh_h;
  logic                unused_addr_hi;

  // Address bits above the memory size are dropped, so addresses wrap.
  assign unused_addr_hi = ^cpu_addr[31:MEM_AW+2];

`ifdef LSU_STORE_FWD_EN
  logic              fwd_valid;
  logic [MEM_AW-1:0] fwd_addr;
  logic [31:0]       fwd_word;
  logic              hit_q;

  assign fwd_hit  = fwd_valid && (fwd_addr == cpu_addr[MEM_AW+1:2]);
  assign cap_word = hit_q ? fwd_word : mem_rdData;

  // The buffer tracks the last word written so a following access to the
  // same word can skip the memory read entirely.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd_valid <= 1'b0;
      fwd_addr  <= '0;
      fwd_word  <= '0;
      hit_q     <= 1'b0;
    end else begin
      if (state == S_IDLE && cpu_req)
        hit_q <= fwd_hit;
      if (state == S_WRITE) begin
        fwd_valid <= 1'b1;
        fwd_addr  <= addr_q[MEM_AW+1:2];
        fwd_word  <= wr_word;
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign cap_word = mem_rdData;
`endif

  // Request checks: halves need even addresses, words need 4-byte alignment,
  // and size 11 is never legal.
  always_comb begin
    req_bad = 1'b0;
    if (cpu_size == 2'b11)
      req_bad = 1'b1;
    else if (cpu_size == 2'b01 && cpu_addr[0])
      req_bad = 1'b1;
    else if (cpu_size == 2'b10 && cpu_addr[1:0] != 2'b00)
      req_bad = 1'b1;
  end

  // Little-endian lane extraction, extension for loads, and lane merge for
  // sub-word stores.
  always_comb begin
    sh_b = {addr_q[1:0], 3'b000};
    sh_h = {addr_q[1], 4'b0000};
    case (addr_q[1:0])
      2'd0:    lane_b = cap_word[7:0];
      2'd1:    lane_b = cap_word[15:8];
      2'd2:    lane_b = cap_word[23:16];
      default: lane_b = cap_word[31:24];
    endcase
    lane_h = addr_q[1] ? cap_word[31:16] : cap_word[15:0];
    case (size_q)
      2'b00: begin
        load_val = {{24{signed_q & lane_b[7]}}, lane_b};
        merged   = (cap_word & ~(32'h0000_00FF << sh_b)) | ({24'b0, wdata_q[7:0]} << sh_b);
      end
      2'b01: begin
        load_val = {{16{signed_q & lane_h[15]}}, lane_h};
        merged   = (cap_word & ~(32'h0000_FFFF << sh_h)) | ({16'b0, wdata_q} << sh_h);
      end
      default: begin
        load_val = cap_word;
        merged   = cap_word;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  // Next state and strobes. Memory strobes come straight from the state so
  // read and write can never overlap.
  always_comb begin
    state_n    = state;
    cpu_ready  = 1'b0;
    cpu_done   = 1'b0;
    cpu_err    = 1'b0;
    mem_rdMem  = 1'b0;
    mem_wrMem  = 1'b0;
    mem_addr   = '0;
    mem_wrData = '0;
    case (state)
      S_IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_req) begin
          if (req_bad)
            state_n = S_ERR;
          else if (cpu_we && cpu_size == 2'b10)
            state_n = S_WRITE;
          else if (fwd_hit)
            state_n = S_CAPTURE;
          else
            state_n = S_READ;
        end
      end
      S_READ: begin
        mem_rdMem = 1'b1;
        mem_addr  = {{(32-MEM_AW){1'b0}}, addr_q[MEM_AW+1:2]};
        if (cnt == CNT_LAST)
          state_n = S_CAPTURE;
      end
      S_CAPTURE: begin
        mem_addr = {{(32-MEM_AW){1'b0}}, addr_q[MEM_AW+1:2]};
        state_n  = we_q ? S_WRITE : S_DONE;
      end
      S_WRITE: begin
        mem_wrMem  = 1'b1;
        mem_addr   = {{(32-MEM_AW){1'b0}}, addr_q[MEM_AW+1:2]};
        mem_wrData = wr_word;
        state_n    = S_DONE;
      end
      S_DONE: begin
        cpu_done = 1'b1;
        state_n  = S_IDLE;
      end
      S_ERR: begin
        cpu_done = 1'b1;
        cpu_err  = 1'b1;
        state_n  = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Request latches, read-latency counter and result registers. wr_word
  // starts as the raw store data (word stores) and is replaced by the merged
  // word for sub-word stores.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      signed_q  <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      wr_word   <= '0;
      cpu_rdata <= '0;
    end else begin
      if (state == S_IDLE && cpu_req) begin
        addr_q   <= cpu_addr[MEM_AW+1:0];
        size_q   <= cpu_size;
        signed_q <= cpu_signed;
        we_q     <= cpu_we;
        wdata_q  <= cpu_wdata[15:0];
        wr_word  <= cpu_wdata;
        cnt      <= '0;
      end
      if (state == S_READ)
        cnt <= cnt + 8'd1;
      if (state == S_CAPTURE) begin
        if (we_q)
          wr_word <= merged;
        else
          cpu_rdata <= load_val;
      end
    end
  end

endmodule
